patch_write_arbiter: RTL and testbench
======================================

PATCH_WRITE_ARBITER -- requirements
Module: patch_write_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of patch requesters (2..8).
REQ-002 Parameter: ADDR_W, 32, byte-address width of the bitstream buffer.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester patch request; held with payload stable until req_ready.
REQ-006 req_addr  input  NUM_REQ*ADDR_W  per-requester start byte address (slot i at [i*ADDR_W +: ADDR_W]).
REQ-007 req_val  input  NUM_REQ*32  per-requester value, right-aligned.
REQ-008 req_bytes  input  NUM_REQ*3  per-requester byte count (0..4 legal).
REQ-009 req_ready  output  NUM_REQ  one-cycle acceptance pulse, one-hot.
REQ-010 mem_we  output  1  byte write strobe to the bitstream buffer.
REQ-011 mem_addr  output  ADDR_W  byte address of the write.
REQ-012 mem_wdata  output  8  byte written.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 patch_done  output  1  one-cycle pulse coincident with the last byte of a request.
REQ-015 err  output  1  one-cycle pulse when a request is dropped.

Function
REQ-016 States: IDLE, WRITE; arbitration only in IDLE.
REQ-017 In IDLE with any req_valid: round-robin winner starting from rr_ptr; latch addr/val/bytes; next cycle enter WRITE with req_ready[winner]=1 for exactly that cycle.
REQ-018 rr_ptr = (winner+1) mod NUM_REQ after every acceptance, including dropped requests.
REQ-019 WRITE emits bytes k=0..n-1 on consecutive cycles: mem_we=1, mem_addr=addr+k (mod 2^ADDR_W), mem_wdata=val[8*(n-1-k)+:8] (big-endian, MSB first).
REQ-020 First byte appears in the same cycle as req_ready: latency 1 cycle from valid to first write.
REQ-021 After byte n-1 (patch_done=1), return to IDLE; one idle cycle between consecutive requests.
REQ-022 req_bytes=0: accepted, WRITE lasts one cycle with mem_we=0 and patch_done=1, no err.
REQ-023 req_bytes 5..7: accepted, no writes, err=1 and patch_done=1 in the req_ready cycle.
REQ-024 req_valid changes while not granted are ignored until IDLE; deasserting valid before ready is a requester error with no defined outcome.
REQ-025 mem_addr/mem_wdata = 0 whenever mem_we=0.

Reset
REQ-026 Asynchronous assertion: state=IDLE, rr_ptr=0, all outputs 0 immediately; in-flight request discarded, never resumed.
REQ-027 Release synchronous to clock; first arbitration on the first rising edge after release.

Configuration
REQ-028 Macro PATCH_RANGE_CHECK_EN defined: adds input buf_limit (ADDR_W) and output err_sticky (1).
REQ-029 With PATCH_RANGE_CHECK_EN: if addr+n > buf_limit (computed at ADDR_W+1 bits), request accepted, no writes, err and patch_done pulse in the req_ready cycle; err_sticky set until reset.
REQ-030 Without PATCH_RANGE_CHECK_EN: ports absent, no range check, addresses wrap per REQ-019.

Structure
REQ-031 Package patch_pkg: state enum (IDLE, WRITE), MAX_BYTES=4, byte-count width 3.
REQ-032 Sub-module rr_arbiter (NUM_REQ req vector + pointer in, one-hot grant and index out), purely combinational.

Verification
REQ-033 Single req 0: addr=0x10, val=0x00001234, bytes=2 -> writes 0x12@0x10, 0x34@0x11; ready at cycle+1; patch_done with 2nd byte.
REQ-034 bytes=4, val=0xA1B2C3D4, addr=0x20 -> 0xA1,0xB2,0xC3,0xD4 at 0x20..0x23 on 4 consecutive cycles, busy high throughout.
REQ-035 All 4 valid together from reset -> grant order 0,1,2,3; req 0 re-asserted after -> served after 3.
REQ-036 Reset asserted after 2nd of 4 bytes -> mem_we low immediately, no further writes, rr_ptr=0 after release.
REQ-037 PATCH_RANGE_CHECK_EN, buf_limit=0x100, addr=0xFE, bytes=4 -> no writes, err pulse, err_sticky=1; bytes=2 -> 2 writes, no err.
REQ-038 bytes=0 and bytes=5 -> no writes; patch_done each; err only for 5.

Source files
------------

// File: rtl/patch_pkg.sv
// Shared types and constants for the patch write arbiter.
package patch_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    localparam int MAX_BYTES = 4;
    localparam int BCNT_W    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan requesters in rotated order starting at ptr; keep the first hit.
    always_comb begin
        int   c;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            c = (int'(ptr) + off) % NUM_REQ;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
        any = found;
    end

endmodule

// File: rtl/patch_write_arbiter.sv
// Patch write arbiter: grants one requester at a time and streams its value
// into the bitstream buffer one byte per cycle, MSB first.
// Optional build macro PATCH_RANGE_CHECK_EN adds buf_limit / err_sticky.
module patch_write_arbiter
    import patch_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_val,
    input  logic [NUM_REQ*3-1:0]      req_bytes,
`ifdef PATCH_RANGE_CHECK_EN
    input  logic [ADDR_W-1:0]         buf_limit,
    output logic                      err_sticky,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      busy,
    output logic                      patch_done,
    output logic                      err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         val_q, val_d;
    logic [BCNT_W-1:0]   bytes_q, bytes_d;
    logic [BCNT_W-1:0]   k_q, k_d;

    logic [NUM_REQ-1:0]  win_grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;

    logic                in_write, first, drop, last, range_bad;
    logic [BCNT_W-1:0]   sh;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // State and latched request registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            val_q    <= '0;
            bytes_q  <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            val_q    <= val_d;
            bytes_q  <= bytes_d;
            k_q      <= k_d;
        end
    end

    // Range check uses one extra bit so addr+n cannot wrap past the limit.
`ifdef PATCH_RANGE_CHECK_EN
    logic err_sticky_q;

    always_comb begin
        range_bad = ({1'b0, addr_q} + (ADDR_W + 1)'(bytes_q)) > {1'b0, buf_limit};
    end

    // Sticky error: set by any range violation, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky_q <= 1'b0;
        end else if (in_write && range_bad) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`else
    assign range_bad = 1'b0;
`endif

    // Decode of the current WRITE cycle.
    always_comb begin
        in_write = (state_q == WRITE);
        first    = (k_q == '0);
        drop     = (bytes_q > BCNT_W'(MAX_BYTES)) || range_bad;
        last     = drop || (bytes_q == '0) || (k_q == bytes_q - BCNT_W'(1));
        sh       = bytes_q - BCNT_W'(1) - k_q;
    end

    // Next-state: arbitrate in IDLE, count bytes in WRITE.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        val_d    = val_q;
        bytes_d  = bytes_q;
        k_d      = k_q;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    state_d  = WRITE;
                    grant_d  = win_grant;
                    addr_d   = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
                    val_d    = req_val[int'(win_idx)*32 +: 32];
                    bytes_d  = req_bytes[int'(win_idx)*3 +: 3];
                    k_d      = '0;
                    rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IDX_W'(1);
                end
            end
            WRITE: begin
                if (last) begin
                    state_d = IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from registered state so reset clears them at once.
    always_comb begin
        req_ready  = (in_write && first) ? grant_q : '0;
        mem_we     = in_write && !drop && (bytes_q != '0);
        mem_addr   = mem_we ? addr_q + ADDR_W'(k_q) : '0;
        mem_wdata  = mem_we ? 8'(val_q >> {sh[1:0], 3'b000}) : 8'h00;
        busy       = in_write;
        patch_done = in_write && last;
        err        = in_write && first && drop;
    end

endmodule

// File: tb/tb_patch_write_arbiter.sv
// Directed self-checking bench for patch_write_arbiter.
module tb_patch_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;

    logic                      clock;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*32-1:0]     req_val;
    logic [NUM_REQ*3-1:0]      req_bytes;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [7:0]                mem_wdata;
    logic                      busy;
    logic                      patch_done;
    logic                      err;
`ifdef PATCH_RANGE_CHECK_EN
    logic [ADDR_W-1:0]         buf_limit;
    logic                      err_sticky;
`endif

    int total;
    int bad;

    patch_write_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_val    (req_val),
        .req_bytes  (req_bytes),
`ifdef PATCH_RANGE_CHECK_EN
        .buf_limit  (buf_limit),
        .err_sticky (err_sticky),
`endif
        .req_ready  (req_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .patch_done (patch_done),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] rdy, input logic we,
                       input logic [31:0] a, input logic [7:0] d, input logic dn,
                       input logic er, input logic bz);
        chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".we"},    32'(mem_we),    32'(we));
        chk({tag, ".addr"},  mem_addr,       a);
        chk({tag, ".wdata"}, 32'(mem_wdata), 32'(d));
        chk({tag, ".done"},  32'(patch_done), 32'(dn));
        chk({tag, ".err"},   32'(err),       32'(er));
        chk({tag, ".busy"},  32'(busy),      32'(bz));
    endtask

    task automatic idle(input string tag);
        cyc(tag, 4'b0000, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] v,
                           input logic [2:0] n);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_val[i*32 +: 32]          = v;
        req_bytes[i*3 +: 3]          = n;
        req_valid[i]                 = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_val   = '0;
        req_bytes = '0;
`ifdef PATCH_RANGE_CHECK_EN
        buf_limit = 32'h100;
`endif
        #12;
        idle("rst");
`ifdef PATCH_RANGE_CHECK_EN
        chk("rst.sticky", 32'(err_sticky), 32'd0);
`endif
        step();
        reset_n = 1'b1;

        // Two-byte patch from requester 0.
        set_req(0, 32'h10, 32'h0000_1234, 3'd2);
        step(); cyc("t1b0", 4'b0001, 1'b1, 32'h10, 8'h12, 1'b0, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); cyc("t1b1", 4'b0000, 1'b1, 32'h11, 8'h34, 1'b1, 1'b0, 1'b1);
        step(); idle("t1i");

        // Four-byte patch, big-endian order, busy throughout.
        set_req(1, 32'h20, 32'hA1B2_C3D4, 3'd4);
        step(); cyc("t2b0", 4'b0010, 1'b1, 32'h20, 8'hA1, 1'b0, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        step(); cyc("t2b1", 4'b0000, 1'b1, 32'h21, 8'hB2, 1'b0, 1'b0, 1'b1);
        step(); cyc("t2b2", 4'b0000, 1'b1, 32'h22, 8'hC3, 1'b0, 1'b0, 1'b1);
        step(); cyc("t2b3", 4'b0000, 1'b1, 32'h23, 8'hD4, 1'b1, 1'b0, 1'b1);
        step(); idle("t2i");

        // All four valid from reset: order 0,1,2,3 then re-asserted 0.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 32'h40 + 32'(i), 32'hA0 + 32'(i), 3'd1);
        step(); cyc("t3g0", 4'b0001, 1'b1, 32'h40, 8'hA0, 1'b1, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); idle("t3i0");
        step(); cyc("t3g1", 4'b0010, 1'b1, 32'h41, 8'hA1, 1'b1, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        step(); idle("t3i1");
        step(); cyc("t3g2", 4'b0100, 1'b1, 32'h42, 8'hA2, 1'b1, 1'b0, 1'b1);
        req_valid[2] = 1'b0;
        req_valid[0] = 1'b1;
        step(); idle("t3i2");
        step(); cyc("t3g3", 4'b1000, 1'b1, 32'h43, 8'hA3, 1'b1, 1'b0, 1'b1);
        req_valid[3] = 1'b0;
        step(); idle("t3i3");
        step(); cyc("t3g0b", 4'b0001, 1'b1, 32'h40, 8'hA0, 1'b1, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); idle("t3i4");

        // Reset after the second of four bytes; pointer returns to 0.
        set_req(0, 32'h80, 32'h1122_3344, 3'd4);
        step(); cyc("t4b0", 4'b0001, 1'b1, 32'h80, 8'h11, 1'b0, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); cyc("t4b1", 4'b0000, 1'b1, 32'h81, 8'h22, 1'b0, 1'b0, 1'b1);
        #1 reset_n = 1'b0;
        #1 idle("t4rst");
        step();
        reset_n = 1'b1;
        set_req(0, 32'h90, 32'h0000_00C0, 3'd1);
        set_req(1, 32'h98, 32'h0000_00C1, 3'd1);
        step(); cyc("t4g0", 4'b0001, 1'b1, 32'h90, 8'hC0, 1'b1, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); idle("t4i0");
        step(); cyc("t4g1", 4'b0010, 1'b1, 32'h98, 8'hC1, 1'b1, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        step(); idle("t4i1");

        // Zero bytes: done without err; five bytes: dropped with err.
        set_req(2, 32'h30, 32'hFFFF_FFFF, 3'd0);
        step(); cyc("t5z", 4'b0100, 1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b1);
        req_valid[2] = 1'b0;
        step(); idle("t5zi");
        set_req(3, 32'h30, 32'hFFFF_FFFF, 3'd5);
        step(); cyc("t5f", 4'b1000, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b1);
        req_valid[3] = 1'b0;
        step(); idle("t5fi");

`ifndef PATCH_RANGE_CHECK_EN
        // Address wraps modulo 2^ADDR_W.
        set_req(0, 32'hFFFF_FFFF, 32'h0000_BEEF, 3'd2);
        step(); cyc("t6b0", 4'b0001, 1'b1, 32'hFFFF_FFFF, 8'hBE, 1'b0, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        step(); cyc("t6b1", 4'b0000, 1'b1, 32'h0, 8'hEF, 1'b1, 1'b0, 1'b1);
        step(); idle("t6i");
`else
        // Range violation drops the request and sets the sticky flag.
        set_req(0, 32'hFE, 32'hDEAD_BEEF, 3'd4);
        step(); cyc("t7d", 4'b0001, 1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b1);
        req_valid[0] = 1'b0;
        step(); idle("t7di");
        chk("t7.sticky", 32'(err_sticky), 32'd1);
        set_req(1, 32'hFE, 32'h0000_5566, 3'd2);
        step(); cyc("t7b0", 4'b0010, 1'b1, 32'hFE, 8'h55, 1'b0, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        step(); cyc("t7b1", 4'b0000, 1'b1, 32'hFF, 8'h66, 1'b1, 1'b0, 1'b1);
        step(); idle("t7i");
        chk("t7.sticky2", 32'(err_sticky), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
